// File: rtl/seven_seg_controller_pkg.sv
// Shared constants for the seven-segment display peripheral: control word
// field layout, blank pin patterns and the default refresh divider.
package seven_seg_controller_pkg;

    localparam int VAL_LSB  = 0;
    localparam int MASK_LSB = 16;
    localparam int DP_LSB   = 20;
    localparam int EN_BIT   = 24;
    localparam int CTRL_W   = 25;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    localparam int DEFAULT_REFRESH_DIV = 100000;

endpackage

// File: rtl/seven_seg_controller_hex_to_seg7.sv
// Hex nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex_to_seg7 (
    input  logic [3:0] hex_in,
    output logic [6:0] seg_out
);

    always_comb begin
        seg_out = 7'h7F;
        case (hex_in)
            4'h0: seg_out = 7'h40;
            4'h1: seg_out = 7'h79;
            4'h2: seg_out = 7'h24;
            4'h3: seg_out = 7'h30;
            4'h4: seg_out = 7'h19;
            4'h5: seg_out = 7'h12;
            4'h6: seg_out = 7'h02;
            4'h7: seg_out = 7'h78;
            4'h8: seg_out = 7'h00;
            4'h9: seg_out = 7'h10;
            4'hA: seg_out = 7'h08;
            4'hB: seg_out = 7'h03;
            4'hC: seg_out = 7'h46;
            4'hD: seg_out = 7'h21;
            4'hE: seg_out = 7'h06;
            4'hF: seg_out = 7'h0E;
            default: seg_out = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seven_seg_controller.sv
// CPU-writable 4-digit multiplexed common-anode display driver: one control
// register, a refresh prescaler, and registered anode/segment/dp outputs.
module seven_seg_controller
    import seven_seg_controller_pkg::*;
#(
    parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV,
    localparam int CNT_W      = $clog2(REFRESH_DIV)
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [31:0] data_from_cpu,
    input  logic        seg_write_en,
    input  logic        seg_read_en,
    output logic [31:0] data_to_cpu,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;

    logic       tick;
    logic [3:0] digit_mask;
    logic [3:0] dp_mask;
    logic [3:0] nibble;
    logic [6:0] decoded;
    logic       slot_lit;
    logic       unused_wdata;

    assign unused_wdata = &{1'b0, data_from_cpu[31:CTRL_W]};

    assign tick       = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    assign digit_mask = ctrl_q[MASK_LSB +: 4];
    assign dp_mask    = ctrl_q[DP_LSB +: 4];
    assign slot_lit   = ctrl_q[EN_BIT] && digit_mask[idx_q];

    always_comb begin
        nibble = ctrl_q[VAL_LSB +: 4];
        case (idx_q)
            2'd0: nibble = ctrl_q[VAL_LSB +: 4];
            2'd1: nibble = ctrl_q[VAL_LSB + 4 +: 4];
            2'd2: nibble = ctrl_q[VAL_LSB + 8 +: 4];
            2'd3: nibble = ctrl_q[VAL_LSB + 12 +: 4];
            default: nibble = ctrl_q[VAL_LSB +: 4];
        endcase
    end

    hex_to_seg7 u_hex_to_seg7 (
        .hex_in  (nibble),
        .seg_out (decoded)
    );

    // Outputs follow the pre-write register, so a write reaches the pins one
    // edge later; the tick edge always blanks to suppress ghosting.
    always_comb begin
        ctrl_d = seg_write_en ? data_from_cpu[CTRL_W-1:0] : ctrl_q;
        cnt_d  = tick ? '0 : cnt_q + 1'b1;
        idx_d  = tick ? idx_q + 2'd1 : idx_q;
        an_d   = AN_OFF;
        seg_d  = SEG_BLANK;
        dp_d   = 1'b1;
        if (!tick && slot_lit) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = decoded;
            dp_d  = ~dp_mask[idx_q];
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            ctrl_q <= '0;
            cnt_q  <= '0;
            idx_q  <= '0;
            an_q   <= AN_OFF;
            seg_q  <= SEG_BLANK;
            dp_q   <= 1'b1;
        end else begin
            ctrl_q <= ctrl_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end
    end

    assign data_to_cpu = seg_read_en ? {7'b0, ctrl_q} : 32'd0;
    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule
